ram_port_arbiter: RTL and testbench

//  Shares the single expansion-RAM port between two toggle-handshake requesters:

---
 rtl/ram_port_arbiter.sv | 78 +++++++
 tb/tb_ram_port_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: serialises two toggle-handshake clients onto one RAM port,
// client 0 first unless client 1 has been passed over starve_limit times in a row.
module ram_port_arbiter #(
    parameter int ram_a_bits   = 17,
    parameter int starve_limit = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ram_a_bits-1:0] c0_a,
    input  logic [7:0]            c0_d,
    input  logic                  c0_we,
    input  logic                  c0_req,
    output logic                  c0_ack,
    output logic [7:0]            c0_q,
    input  logic [ram_a_bits-1:0] c1_a,
    input  logic [7:0]            c1_d,
    input  logic                  c1_we,
    input  logic                  c1_req,
    output logic                  c1_ack,
    output logic [7:0]            c1_q,
    output logic [ram_a_bits-1:0] ram_a,
    output logic [7:0]            ram_d,
    output logic                  ram_we,
    output logic                  ram_req,
    input  logic                  ram_ack,
    input  logic [7:0]            ram_q
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [3:0] lim = 4'(starve_limit);
    state_t     state, state_next;
    logic       owner;
    logic [3:0] starve_cnt;
    logic       p0, p1, pick1, grant, done;
    assign p0    = c0_req ^ c0_ack;
    assign p1    = c1_req ^ c1_ack;
    assign pick1 = p1 && (!p0 || starve_cnt == lim);
    assign grant = p0 || p1;
    assign done  = ram_req == ram_ack;
    always_comb begin
        state_next = (state == IDLE) ? (grant ? BUSY : IDLE) : (done ? IDLE : BUSY);
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            c0_ack     <= c0_req;
            c1_ack     <= c1_req;
            ram_req    <= ram_ack;
            ram_we     <= 1'b0;
            ram_a      <= '0;
            ram_d      <= '0;
            c0_q       <= '0;
            c1_q       <= '0;
            starve_cnt <= '0;
            owner      <= 1'b0;
        end else if (state == IDLE) begin
            // ram_req follows ram_ack while idle so an ack from an abandoned transaction is absorbed
            ram_req <= grant ? ~ram_ack : ram_ack;
            if (grant) begin
                ram_a      <= pick1 ? c1_a : c0_a;
                ram_d      <= pick1 ? c1_d : c0_d;
                ram_we     <= pick1 ? c1_we : c0_we;
                owner      <= pick1;
                starve_cnt <= pick1 ? 4'd0 : (p1 && starve_cnt != lim) ? starve_cnt + 4'd1 : starve_cnt;
            end
        end else if (done) begin
            if (owner) begin
                c1_q   <= ram_q;
                c1_ack <= ~c1_ack;
            end else begin
                c0_q   <= ram_q;
                c0_ack <= ~c0_ack;
            end
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: random two-client traffic against a randomly delayed RAM,
// checked every cycle against a transaction-level reference model.
module tb_ram_port_arbiter;
    localparam int AW  = 17;
    localparam int LIM = 4;
    localparam logic [AW-1:0] BASE = 17'h1F000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] ca [2];
    logic [7:0]    cd [2];
    logic [7:0]    cq [2];
    logic [1:0]    we = 2'b00;
    logic [1:0]    req = 2'b01;
    logic [1:0]    ack;
    logic [AW-1:0] ram_a;
    logic [7:0]    ram_d;
    logic          ram_we, ram_req;
    logic          ram_ack = 1'b1;
    logic [7:0]    ram_q = 8'h00;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ram_a_bits(AW), .starve_limit(LIM)) dut (
        .clk(clk), .reset(reset),
        .c0_a(ca[0]), .c0_d(cd[0]), .c0_we(we[0]), .c0_req(req[0]), .c0_ack(ack[0]), .c0_q(cq[0]),
        .c1_a(ca[1]), .c1_d(cd[1]), .c1_we(we[1]), .c1_req(req[1]), .c1_ack(ack[1]), .c1_q(cq[1]),
        .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_req(ram_req), .ram_ack(ram_ack), .ram_q(ram_q)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model state
    logic [1:0]    m_ack, p;
    logic          m_busy = 1'b0, m_owner = 1'b0, m_rreq = 1'b0, g;
    int            m_cnt = 0;
    logic [7:0]    exp_q [2];
    logic [AW-1:0] m_ra;
    logic [7:0]    m_rd;
    logic          m_rwe;
    logic [7:0]    ref_mem [16];
    // RAM responder state
    logic [7:0]    ram_mem [16];
    logic          rsp_busy = 1'b0, rsp_we = 1'b0;
    int            rsp_cnt = 0;
    logic [3:0]    rsp_idx = '0;
    logic [7:0]    rsp_d = '0;
    // traffic control
    int            reset_left = 1, n_resets = 0, prob = 50;
    logic          quiet = 1'b0;

    initial begin
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 8'(i * 37 + 5);
            ram_mem[i] = 8'(i * 37 + 5);
        end
        for (int i = 0; i < 2; i++) begin
            ca[i] = BASE;
            cd[i] = '0;
            exp_q[i] = '0;
        end
        m_ack = 2'b00; m_ra = '0; m_rd = '0; m_rwe = 1'b0;
        for (int cyc = 0; cyc < 2400; cyc++) begin
            @(posedge clk);
            #1;
            if (reset) begin
                if (m_busy && m_rwe) ref_mem[m_ra[3:0]] = m_rd;
                m_ack = req; m_rreq = ram_ack; m_busy = 1'b0; m_cnt = 0;
                exp_q[0] = '0; exp_q[1] = '0; m_ra = '0; m_rd = '0; m_rwe = 1'b0;
            end else if (!m_busy) begin
                p = req ^ m_ack;
                if (p != 2'b00) begin
                    g = p[1] && (!p[0] || m_cnt == LIM);
                    if (g) m_cnt = 0;
                    else if (p[1]) m_cnt = (m_cnt < LIM) ? m_cnt + 1 : LIM;
                    m_owner = g; m_busy = 1'b1;
                    m_ra = ca[g]; m_rd = cd[g]; m_rwe = we[g];
                    m_rreq = ~ram_ack;
                end else m_rreq = ram_ack;
            end else if (ram_ack == m_rreq) begin
                m_busy = 1'b0;
                m_ack[m_owner] = ~m_ack[m_owner];
                if (m_rwe) begin
                    exp_q[m_owner] = ram_q;
                    ref_mem[m_ra[3:0]] = m_rd;
                end else exp_q[m_owner] = ref_mem[m_ra[3:0]];
            end
            check("c0_ack", ack[0], m_ack[0]);
            check("c1_ack", ack[1], m_ack[1]);
            check("c0_q", cq[0], exp_q[0]);
            check("c1_q", cq[1], exp_q[1]);
            check("ram_req", ram_req, m_rreq);
            check("ram_a", ram_a, m_ra);
            check("ram_d", ram_d, m_rd);
            check("ram_we", ram_we, m_rwe);
            // RAM responder: latches the command, answers after 0..3 cycles
            if (!rsp_busy && ram_req !== ram_ack) begin
                rsp_busy = 1'b1; rsp_cnt = $urandom_range(0, 3);
                rsp_idx = ram_a[3:0]; rsp_d = ram_d; rsp_we = ram_we;
            end
            if (rsp_busy) begin
                if (rsp_cnt == 0) begin
                    if (rsp_we) begin
                        ram_mem[rsp_idx] = rsp_d;
                        ram_q = 8'($urandom);
                    end else ram_q = ram_mem[rsp_idx];
                    ram_ack = ~ram_ack;
                    rsp_busy = 1'b0;
                end else rsp_cnt--;
            end
            // reset control, including resets that abandon a transaction in flight
            if (reset_left > 0) begin
                reset_left--;
                reset = 1'b1;
            end else if (cyc > 20 && m_busy && ((n_resets == 0 && cyc >= 300) || $urandom_range(0, 59) == 0)) begin
                reset = 1'b1; reset_left = $urandom_range(0, 1); quiet = 1'b1; n_resets++;
            end else reset = 1'b0;
            if (!reset && quiet && !rsp_busy && ram_req === ram_ack) quiet = 1'b0;
            prob = (cyc < 800) ? 50 : (cyc < 1600) ? 100 : 30;
            if (!reset && !quiet)
                for (int i = 0; i < 2; i++)
                    if (req[i] == ack[i] && $urandom_range(0, 99) < prob) begin
                        ca[i] = BASE | AW'($urandom_range(0, 15));
                        cd[i] = 8'($urandom);
                        we[i] = 1'($urandom);
                        req[i] = ~req[i];
                    end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
